// File: rtl/signal_maker_arb_pkg.sv
// Shared definitions for the signal maker arbiter: FSM encoding and default sizing.
package signal_maker_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int DEF_SHIFT_LEN = 6;
  localparam int DEF_GAP_LEN   = 1;
  localparam int DEF_PAT_W     = 6;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/signal_maker_arb_rr_arb2.sv
// Two-input round-robin arbiter; the last-served pointer only moves when upd_en is high.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd_en,
  output logic [1:0] gnt,
  output logic       win
);

  logic last_q;
  logic last_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
    gnt    = (req == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
    last_d = (upd_en && (req != 2'b00)) ? win : last_q;
  end

  // Pointer resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/signal_maker_arb.sv
// Arbitrates two requesters onto a serial signal maker: latch pattern, load, shift, gap.
module signal_maker_arb
  import signal_maker_arb_pkg::*;
#(
  parameter int SHIFT_LEN = DEF_SHIFT_LEN,
  parameter int GAP_LEN   = DEF_GAP_LEN,
  parameter int PAT_W     = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [PAT_W-1:0] pat0,
  input  logic [PAT_W-1:0] pat1,
  output logic [1:0]       gnt,
  output logic             done,
  output logic             busy,
  output logic             owner,
  output logic             sm_load,
  output logic [PAT_W-1:0] sm_din,
  output logic [1:0]       dbg_state
);

  localparam int CNT_MAX = max3(SHIFT_LEN, GAP_LEN, 1);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] SHIFT_INIT = CNT_W'(SHIFT_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             owner_q, owner_d;
  logic             sm_load_q, sm_load_d;
  logic [PAT_W-1:0] sm_din_q, sm_din_d;

  logic [1:0] arb_gnt;
  logic       arb_win;
  logic       arb_en;

  assign arb_en = (state_q == ST_IDLE) && (req != 2'b00);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .upd_en (arb_en),
    .gnt    (arb_gnt),
    .win    (arb_win)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    sm_din_d  = sm_din_q;
    gnt_d     = 2'b00;
    sm_load_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_d   = ST_LOAD;
          owner_d   = arb_win;
          sm_din_d  = arb_win ? pat1 : pat0;
          gnt_d     = arb_gnt;
          sm_load_d = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        cnt_d   = SHIFT_INIT;
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          if (GAP_LEN > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_INIT;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered, so decode them from the upcoming state.
    done_d = (state_d == ST_SHIFT) && (cnt_d == '0);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gnt_q     <= 2'b00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      owner_q   <= 1'b0;
      sm_load_q <= 1'b0;
      sm_din_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      sm_load_q <= sm_load_d;
      sm_din_q  <= sm_din_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign sm_load   = sm_load_q;
  assign sm_din    = sm_din_q;
  assign dbg_state = state_q;

endmodule

// File: doc/signal_maker_arb.md
SIGNAL_MAKER_ARB -- requirements
Module: signal_maker_arb

Interface
REQ-001 Parameter SHIFT_LEN, default 6: number of serial bit cycles the downstream signal maker needs per loaded pattern.
REQ-002 Parameter GAP_LEN, default 1: idle cycles inserted after each frame before the next arbitration; 0 is legal.
REQ-003 Parameter PAT_W, default 6: pattern width.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  2  level request per requester; bit i is requester i.
REQ-007 pat0  input  PAT_W  pattern of requester 0, sampled on grant.
REQ-008 pat1  input  PAT_W  pattern of requester 1, sampled on grant.
REQ-009 gnt  output  2  one-cycle, one-hot grant pulse; the pattern was captured.
REQ-010 done  output  1  one-cycle pulse in the last shift cycle of a frame.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 owner  output  1  index of the requester whose frame is in flight; valid while busy.
REQ-013 sm_load  output  1  load strobe to the signal maker.
REQ-014 sm_din  output  PAT_W  pattern to the signal maker; held stable from LOAD through the end of SHIFT.

Function
REQ-015 FSM states: IDLE, LOAD, SHIFT, GAP; the FSM and all outputs are registered.
REQ-016 IDLE: if req != 0 at a clock edge, arbitrate, latch the winner's pattern into sm_din, set owner, and go to LOAD; otherwise stay in IDLE.
REQ-017 Arbitration: a single requester always wins; if both request, the one not served last wins (round robin).
REQ-018 LOAD lasts exactly 1 cycle, with sm_load=1 and gnt[owner]=1; then go to SHIFT.
REQ-019 SHIFT lasts exactly SHIFT_LEN cycles, counted by a down-counter loaded with SHIFT_LEN-1; done=1 in the cycle the counter reads 0.
REQ-020 After SHIFT, go to GAP for GAP_LEN cycles, or to IDLE directly when GAP_LEN=0.
REQ-021 Frame period from a request sampled in IDLE to the next possible LOAD is 1+SHIFT_LEN+GAP_LEN+1 cycles (9 with defaults).
REQ-022 Requests are ignored outside IDLE; a request still held in IDLE is re-arbitrated (no queuing, no loss of a held level).
REQ-023 Pattern inputs are sampled only at the IDLE->LOAD edge; later changes have no effect on the frame in flight.
REQ-024 sm_load and gnt are never high outside LOAD; gnt is never 2'b11.
REQ-025 Counter width is clog2(max(SHIFT_LEN,GAP_LEN,1))+1 bits; it never wraps below 0.

Reset
REQ-026 While rst=1: state IDLE; gnt=0, done=0, busy=0, sm_load=0, sm_din=0, owner=0, counter=0, last-served pointer=1 (requester 0 wins the first tie).
REQ-027 Reset asserted mid-frame aborts the frame at the next edge; no done pulse is produced for the aborted frame.
REQ-028 The first arbitration can occur at the first edge with rst=0.

Structure
REQ-029 The shared package holds the state enumeration (IDLE, LOAD, SHIFT, GAP) and the default constants SHIFT_LEN=6, GAP_LEN=1, PAT_W=6.
REQ-030 One sub-module, rr_arb2: a 2-input round-robin arbiter with a pointer update-enable; the FSM, counter and datapath registers stay in signal_maker_arb.

Verification
REQ-031 Single request: req=01, pat0=6'b100111 at cycle 0 -> LOAD at cycle 1 (sm_load=1, gnt=01, sm_din=100111); done at cycle 7; busy falls at cycle 9.
REQ-032 Both requesters held at 11 from reset -> grants go 01, 10, 01, 10, with consecutive LOADs 9 cycles apart.
REQ-033 pat0 changed to 6'b000001 during SHIFT -> sm_din stays 100111 until the frame ends.
REQ-034 rst pulsed at the 3rd SHIFT cycle -> next cycle all outputs are 0 and state is IDLE; no done pulse; the next tie is granted to requester 0.
REQ-035 GAP_LEN=0, SHIFT_LEN=3, req=10 held -> LOADs 5 cycles apart; done pulses every 5 cycles.
REQ-036 Throughout all scenarios, assertion checks: gnt one-hot or zero, sm_load==|gnt, done only in SHIFT.
